// File: rtl/uart_lcd_writer_pkg.sv
// Shared definitions for the UART-to-HD44780 writer: FSM states, LCD command bytes,
// control characters and compile-time timing helpers.
package uart_lcd_writer_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_DECODE,
        ST_ADDR,
        ST_SETUP,
        ST_E_HIGH,
        ST_WAIT
    } state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE0    = 8'h80;
    localparam logic [7:0] LCD_LINE1    = 8'hC0;

    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;

    localparam int SETUP_CYC = 2;
    localparam int INIT_LEN  = 4;

    // Rounds up so that every LCD timing is met, never shorter than one cycle.
    function automatic int to_cycles(longint freq_hz, longint amount, longint per_sec);
        longint c;
        c = (freq_hz * amount + per_sec - 1) / per_sec;
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic logic [7:0] init_cmd(logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    function automatic logic [7:0] line_cmd(logic line);
        return line ? LCD_LINE1 : LCD_LINE0;
    endfunction

    function automatic logic is_printable(logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_lcd_writer_fifo.sv
// Synchronous byte FIFO with registered read; a pop presents the head byte on dout_o
// the following cycle. Pushes while full are ignored.
module lcd_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [7:0]    dout_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = dout_q;
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers are power-of-two wide, so they wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_lcd_writer.sv
// Renders UART bytes on a 16x2 HD44780 over an 8-bit write-only bus: power-up init,
// buffered input, cursor tracking with line wrap, CR/LF/FF handling.
module uart_lcd_writer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int FIFO_DEPTH  = 16,
    parameter int LCD_COLS    = 16,
    parameter int PWRUP_US    = 20000,
    parameter int CMD_US      = 50,
    parameter int CLR_US      = 2000,
    parameter int E_NS        = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          lcd_rs,
    output logic                          lcd_rw,
    output logic                          lcd_e,
    output logic [7:0]                    lcd_data,
    output logic                          init_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    import uart_lcd_writer_pkg::*;

    localparam int PWRUP_CYC = to_cycles(CLK_FREQ_HZ, PWRUP_US, 1_000_000);
    localparam int CMD_CYC   = to_cycles(CLK_FREQ_HZ, CMD_US, 1_000_000);
    localparam int CLR_CYC   = to_cycles(CLK_FREQ_HZ, CLR_US, 1_000_000);
    localparam int E_CYC     = to_cycles(CLK_FREQ_HZ, E_NS, 1_000_000_000);
    localparam int MAX_A     = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int MAX_B     = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam int CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int COL_W     = $clog2(LCD_COLS + 1);

    localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] E_LOAD     = CNT_W'(E_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(LCD_COLS - 1);

    state_t           state_q;
    state_t           ret_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       init_idx_q;
    logic [COL_W-1:0] col_q;
    logic             line_q;
    logic             rs_q;
    logic             e_q;
    logic [7:0]       data_q;
    logic             init_done_q;
    logic             overflow_q;

    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    lcd_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .din_i   (in_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_data  = data_q;
    assign init_done = init_done_q;
    assign overflow  = overflow_q;

    // Every bus transfer runs SETUP -> E_HIGH -> WAIT and then resumes at ret_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWR_WAIT;
            ret_q       <= ST_IDLE;
            cnt_q       <= PWR_LOAD;
            init_idx_q  <= '0;
            col_q       <= '0;
            line_q      <= 1'b0;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            data_q      <= '0;
            init_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (in_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_PWR_WAIT: begin
                    if (cnt_q == '0) state_q <= ST_INIT;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                ST_INIT: begin
                    if (init_idx_q == 3'(INIT_LEN)) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rs_q       <= 1'b0;
                        data_q     <= init_cmd(init_idx_q[1:0]);
                        init_idx_q <= init_idx_q + 1'b1;
                        ret_q      <= ST_INIT;
                        cnt_q      <= SETUP_LOAD;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    ret_q   <= ST_IDLE;
                    cnt_q   <= SETUP_LOAD;
                    state_q <= ST_SETUP;
                    if (is_printable(fifo_dout)) begin
                        rs_q   <= 1'b1;
                        data_q <= fifo_dout;
                        if (col_q == COL_LAST) begin
                            col_q  <= '0;
                            line_q <= ~line_q;
                            ret_q  <= ST_ADDR;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end else if (fifo_dout == CHR_CR) begin
                        rs_q   <= 1'b0;
                        data_q <= line_cmd(line_q);
                        col_q  <= '0;
                    end else if (fifo_dout == CHR_LF) begin
                        rs_q   <= 1'b0;
                        data_q <= line_cmd(~line_q);
                        line_q <= ~line_q;
                        col_q  <= '0;
                    end else if (fifo_dout == CHR_FF) begin
                        rs_q   <= 1'b0;
                        data_q <= LCD_CLEAR;
                        line_q <= 1'b0;
                        col_q  <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    rs_q    <= 1'b0;
                    data_q  <= line_cmd(line_q);
                    ret_q   <= ST_IDLE;
                    cnt_q   <= SETUP_LOAD;
                    state_q <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= E_LOAD;
                        state_q <= ST_E_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_E_HIGH: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= (!rs_q && data_q == LCD_CLEAR) ? CLR_LOAD : CMD_LOAD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_q <= ret_q;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= ST_PWR_WAIT;
            endcase
        end
    end

endmodule
